// File: rtl/decode_read_stage_pkg.sv
// Shared pipeline constants for the decode/read stage and its register file.
// Pure declarations; no logic, no latency.
// No flow control lives here.
package decode_read_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;
  localparam int ZERO_REG  = 0;

endpackage : decode_read_stage_pkg

// File: rtl/decode_read_stage_regfile_2r1w.sv
// Register file: two combinational write-through read ports, one synchronous write port.
// Reads are same-cycle; writes commit at the rising edge.
// No backpressure: a write is accepted every cycle it is enabled (outside reset).
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import decode_read_stage_pkg::*;

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              wr_en;

  // Register 0 is hardwired, so a write aimed at it is simply not a write.
  assign wr_en = we && (waddr != ADDR_W'(ZERO_REG));

  // Next-state of the array: one entry replaced on a qualified write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[ZERO_REG] = '0;
  end

  // Array storage; reset wins over a writeback in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: forward the in-flight writeback so decode never sees stale data.
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (wr_en && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (raddr1 == ADDR_W'(ZERO_REG)) begin
      rdata1 = '0;
    end
  end

  // Read port 2: same forwarding rule as port 1.
  always_comb begin
    rdata2 = regs_q[raddr2];
    if (wr_en && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
    if (raddr2 == ADDR_W'(ZERO_REG)) begin
      rdata2 = '0;
    end
  end

endmodule : regfile_2r1w

// File: rtl/decode_read_stage.sv
// Decode read stage: register-file read plus the ID/EX pipeline register.
// One cycle from decode presentation to RD1E/RD2E/RsE/RtE/ValidE.
// StallD holds the ID/EX register (operands still refreshed by writeback); FlushE inserts a bubble.
module decode_read_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] WriteDataW,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
  input  logic              ValidD,
  input  logic              StallD,
  input  logic              FlushE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [ADDR_W-1:0] RsE,
  output logic [ADDR_W-1:0] RtE,
  output logic              ValidE
);
  import decode_read_stage_pkg::*;

  logic [DATA_W-1:0] rd1_dec;
  logic [DATA_W-1:0] rd2_dec;

  logic [DATA_W-1:0] rd1_e_q, rd1_e_d;
  logic [DATA_W-1:0] rd2_e_q, rd2_e_d;
  logic [ADDR_W-1:0] rs_e_q,  rs_e_d;
  logic [ADDR_W-1:0] rt_e_q,  rt_e_d;
  logic              valid_e_q, valid_e_d;

  logic              wb_live;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk    (Clk),
    .rst    (Reset),
    .we     (RegWriteW),
    .waddr  (WriteRegW),
    .wdata  (WriteDataW),
    .raddr1 (RsD),
    .raddr2 (RtD),
    .rdata1 (rd1_dec),
    .rdata2 (rd2_dec)
  );

  // A writeback to register 0 never changes architectural state, so it never refreshes.
  assign wb_live = RegWriteW && (WriteRegW != ADDR_W'(ZERO_REG));

  // ID/EX next state: flush beats stall beats normal capture.
  always_comb begin
    rd1_e_d   = rd1_e_q;
    rd2_e_d   = rd2_e_q;
    rs_e_d    = rs_e_q;
    rt_e_d    = rt_e_q;
    valid_e_d = valid_e_q;
    if (FlushE) begin
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      rs_e_d    = '0;
      rt_e_d    = '0;
      valid_e_d = 1'b0;
    end else if (StallD) begin
      // Held operands track writebacks to their source registers so they are current on release.
      if (wb_live && (WriteRegW == rs_e_q)) begin
        rd1_e_d = WriteDataW;
      end
      if (wb_live && (WriteRegW == rt_e_q)) begin
        rd2_e_d = WriteDataW;
      end
    end else begin
      rd1_e_d   = rd1_dec;
      rd2_e_d   = rd2_dec;
      rs_e_d    = RsD;
      rt_e_d    = RtD;
      valid_e_d = ValidD;
    end
  end

  // ID/EX register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      rs_e_q    <= '0;
      rt_e_q    <= '0;
      valid_e_q <= 1'b0;
    end else begin
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      valid_e_q <= valid_e_d;
    end
  end

  assign RD1E   = rd1_e_q;
  assign RD2E   = rd2_e_q;
  assign RsE    = rs_e_q;
  assign RtE    = rt_e_q;
  assign ValidE = valid_e_q;

endmodule : decode_read_stage

// File: tb/tb_decode_read_stage.sv
// Bench for decode_read_stage: directed scenarios then randomized traffic vs. a reference model.
// Every step advances one clock and compares all outputs 1 time unit after the edge.
// No flow control on the DUT; the bench drives every cycle.
module tb_decode_read_stage;

  logic        Clk;
  logic        Reset;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] WriteDataW;
  logic [4:0]  RsD, RtD;
  logic        ValidD, StallD, FlushE;
  logic [31:0] RD1E, RD2E;
  logic [4:0]  RsE, RtE;
  logic        ValidE;

  int checks;
  int errors;

  // Reference state: architectural register contents and the expected ID/EX view.
  logic [31:0] m_rf [32];
  logic [31:0] m_rd1, m_rd2;
  logic [4:0]  m_rs, m_rt;
  logic        m_valid;

  decode_read_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .RegWriteW  (RegWriteW),
    .WriteRegW  (WriteRegW),
    .WriteDataW (WriteDataW),
    .RsD        (RsD),
    .RtD        (RtD),
    .ValidD     (ValidD),
    .StallD     (StallD),
    .FlushE     (FlushE),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .RsE        (RsE),
    .RtE        (RtE),
    .ValidE     (ValidE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a decode read of register idx should return this cycle.
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == idx) return WriteDataW;
    return m_rf[idx];
  endfunction

  // Advance the model one edge from the current inputs, clock the DUT, then compare.
  task automatic step(input string tag);
    logic [31:0] n_rd1, n_rd2;
    logic        wb_ok;
    wb_ok = RegWriteW && (WriteRegW != 5'd0);
    n_rd1 = m_read(RsD);
    n_rd2 = m_read(RtD);
    if (Reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_rd1 = 0; m_rd2 = 0; m_rs = 0; m_rt = 0; m_valid = 0;
    end else begin
      if (FlushE) begin
        m_rd1 = 0; m_rd2 = 0; m_rs = 0; m_rt = 0; m_valid = 0;
      end else if (StallD) begin
        if (wb_ok && WriteRegW == m_rs) m_rd1 = WriteDataW;
        if (wb_ok && WriteRegW == m_rt) m_rd2 = WriteDataW;
      end else begin
        m_rd1 = n_rd1; m_rd2 = n_rd2; m_rs = RsD; m_rt = RtD; m_valid = ValidD;
      end
      if (wb_ok) m_rf[WriteRegW] = WriteDataW;
    end
    @(posedge Clk);
    #1;
    chk({tag, ".RD1E"},   RD1E,          m_rd1);
    chk({tag, ".RD2E"},   RD2E,          m_rd2);
    chk({tag, ".RsE"},    {27'd0, RsE},  {27'd0, m_rs});
    chk({tag, ".RtE"},    {27'd0, RtE},  {27'd0, m_rt});
    chk({tag, ".ValidE"}, {31'd0, ValidE}, {31'd0, m_valid});
  endtask

  task automatic idle();
    RegWriteW = 0; WriteRegW = 0; WriteDataW = 0;
    RsD = 0; RtD = 0; ValidD = 0; StallD = 0; FlushE = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    RegWriteW = 1; WriteRegW = r; WriteDataW = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    idle();

    // Reset with a same-cycle writeback to r3 that must be dropped; hold reset a few cycles.
    Reset = 1;
    wb(5'd3, 32'h0000_0077);
    RsD = 5'd3; RtD = 5'd3; ValidD = 1;
    step("reset0");
    for (int i = 0; i < 2; i++) begin
      wb(5'($urandom_range(1, 31)), $urandom);
      RsD = 5'($urandom); RtD = 5'($urandom);
      step("reset_hold");
      chk("reset_hold.RD1E_zero", RD1E, 32'd0);
    end
    Reset = 0;
    idle();
    step("post_reset");

    // Reset-cycle write of r3 was discarded.
    RsD = 5'd3; ValidD = 1;
    step("r3_discarded");
    chk("r3_discarded.const", RD1E, 32'd0);

    // Write r5, read it next cycle.
    idle();
    wb(5'd5, 32'h0000_00AA);
    step("wr_r5");
    idle();
    RsD = 5'd5; ValidD = 1;
    step("rd_r5");
    chk("rd_r5.const", RD1E, 32'h0000_00AA);
    chk("rd_r5.valid", {31'd0, ValidE}, 32'd1);

    // Same-cycle write-through to both ports.
    idle();
    wb(5'd7, 32'h1234_5678);
    RsD = 5'd7; RtD = 5'd7; ValidD = 1;
    step("wt_r7");
    chk("wt_r7.rd2_const", RD2E, 32'h1234_5678);

    // Writes to r0 are ignored, including through the forwarding path.
    idle();
    wb(5'd0, 32'hFFFF_FFFF);
    RsD = 5'd0; ValidD = 1;
    step("wr_r0_same");
    idle();
    RsD = 5'd0; ValidD = 1;
    step("rd_r0");
    chk("rd_r0.const", RD1E, 32'd0);

    // ValidD=0 still captures indices and data.
    idle();
    RsD = 5'd5; RtD = 5'd7; ValidD = 0;
    step("bubble_capture");

    // Stall with writeback to the held source register.
    idle();
    wb(5'd9, 32'd1);
    step("wr_r9");
    idle();
    RsD = 5'd9; RtD = 5'd9; ValidD = 1;
    step("cap_r9");
    chk("cap_r9.const", RD1E, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      StallD = 1;
      RsD = 5'($urandom); RtD = 5'($urandom); ValidD = 1'($urandom);
      if (i == 1) wb(5'd9, 32'h0000_0055);
      step("stall_r9");
      chk("stall_r9.RsE_const", {27'd0, RsE}, 32'd9);
      chk("stall_r9.ValidE_const", {31'd0, ValidE}, 32'd1);
    end
    chk("stall_r9.RD1E_const", RD1E, 32'h0000_0055);
    chk("stall_r9.RD2E_const", RD2E, 32'h0000_0055);

    // Flush beats stall.
    idle();
    StallD = 1; FlushE = 1;
    step("flush_stall");
    chk("flush_stall.ValidE_const", {31'd0, ValidE}, 32'd0);

    // Randomized traffic, indices biased to a few registers so forwarding and refresh hit often.
    for (int n = 0; n < 400; n++) begin
      Reset      = ($urandom_range(0, 49) == 0);
      FlushE     = ($urandom_range(0, 7) == 0);
      StallD     = ($urandom_range(0, 3) == 0);
      ValidD     = 1'($urandom);
      RegWriteW  = 1'($urandom);
      WriteRegW  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      WriteDataW = $urandom;
      RsD        = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      RtD        = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decode_read_stage

// File: doc/decode_read_stage.md
DECODE_READ_STAGE -- requirements
Module: decode_read_stage

Interface
REQ-001 Parameter: DATA_W, 32, register/operand width.
REQ-002 Parameter: ADDR_W, 5, register index width (2^ADDR_W = 32 registers).
REQ-003 Port: Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset.
REQ-005 Port: RegWriteW  in  1  writeback write enable.
REQ-006 Port: WriteRegW  in  ADDR_W  writeback destination index.
REQ-007 Port: WriteDataW  in  DATA_W  writeback data.
REQ-008 Port: RsD, RtD  in  ADDR_W each  decode-stage source indices.
REQ-009 Port: ValidD  in  1  decode stage holds a real instruction.
REQ-010 Port: StallD  in  1  hold ID/EX register contents.
REQ-011 Port: FlushE  in  1  insert bubble into ID/EX register.
REQ-012 Port: RD1E, RD2E  out  DATA_W each  registered source operands.
REQ-013 Port: RsE, RtE  out  ADDR_W each  registered source indices.
REQ-014 Port: ValidE  out  1  ID/EX register holds a real instruction.

Function
REQ-015 Register file SHALL hold 32 x DATA_W entries; register 0 SHALL always read 0 and ignore writes.
REQ-016 Write SHALL occur at rising Clk when RegWriteW=1, WriteRegW!=0, Reset=0.
REQ-017 Decode read SHALL be write-through: if RegWriteW=1, WriteRegW!=0 and WriteRegW equals RsD (RtD), read data SHALL be WriteDataW, else stored value.
REQ-018 ID/EX capture latency SHALL be exactly 1 cycle: RD1E/RD2E/RsE/RtE/ValidE take decode-read values at the rising edge following presentation.
REQ-019 Priority at each edge SHALL be Reset > FlushE > StallD > capture.
REQ-020 FlushE=1 SHALL set ValidE=0 and RD1E, RD2E, RsE, RtE to 0, regardless of StallD.
REQ-021 StallD=1 (FlushE=0) SHALL hold RsE, RtE, ValidE unchanged.
REQ-022 During stall, if RegWriteW=1, WriteRegW!=0 and WriteRegW==RsE (RtE), RD1E (RD2E) SHALL update to WriteDataW so held operands never go stale; both SHALL update if RsE==RtE.
REQ-023 Register-file write SHALL proceed independently of StallD and FlushE.
REQ-024 ValidD=0 SHALL still capture indices/data but set ValidE=0.

Reset
REQ-025 Reset=1 SHALL clear all 32 registers and set RD1E, RD2E, RsE, RtE, ValidE to 0 at the next rising edge.
REQ-026 A writeback asserted in the same cycle as Reset SHALL be discarded.
REQ-027 Outputs SHALL remain 0 while Reset is held; first capture occurs at the first edge with Reset=0.

Structure
REQ-028 DATA_W, ADDR_W, REG_COUNT (32) and ZERO_REG (0) SHALL live in the shared pipeline package.
REQ-029 Storage SHALL be a sub-module regfile_2r1w (two combinational read ports with write-through, one synchronous write port, register-0 masking); decode_read_stage SHALL hold the ID/EX register and stall-refresh logic.

Verification
REQ-030 Reset, then write r5=0x0000_00AA; next cycle RsD=5 -> RD1E=0x0000_00AA one edge later, ValidE follows ValidD.
REQ-031 Same-cycle write r7=0x1234_5678 with RsD=RtD=7 -> RD1E=RD2E=0x1234_5678 after that edge.
REQ-032 Write r0=0xFFFF_FFFF, then RsD=0 -> RD1E=0.
REQ-033 Capture RsE=9 (r9=1), assert StallD 3 cycles while WB writes r9=0x55 -> RD1E=0x55, RsE=9, ValidE unchanged throughout.
REQ-034 FlushE=1 with StallD=1 -> ValidE=0, RD1E=RD2E=0, RsE=RtE=0.
REQ-035 Write r3=0x77 with Reset=1 same cycle; release Reset; read r3 -> RD1E=0.
